// File: rtl/polar_encoder_pkg.sv
// polar_encoder_pkg: shared code parameters, FSM state encoding and frozen-mask helpers
// Holds the default N/K/log2(N)/frozen-set definitions used by both the encoder and the decoder.
// mask_rank() and mask_popcount() are evaluated at elaboration to wire the info-bit mapping.
package polar_encoder_pkg;

   localparam int BIT_N = 16;
   localparam int BIT_K = 8;
   localparam int BIT_LOG2N = 4;
   localparam logic [BIT_N-1:0] BIT_FROZEN_MASK = 16'hFE80;
   localparam int MAX_N = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      DONE = 2'd2
   } enc_state_t;

   // number of set mask bits strictly below idx = info-bit index that lands on u[idx]
   function automatic int mask_rank(input logic [MAX_N-1:0] mask, input int idx);
      int r;
      r = 0;
      for (int b = 0; b < idx; b++) r += int'(mask[b]);
      return r;
   endfunction

   function automatic int mask_popcount(input logic [MAX_N-1:0] mask);
      return mask_rank(mask, MAX_N);
   endfunction

endpackage

// File: rtl/polar_encoder_if.sv
// polar_encoder_if: frame-in / codeword-out valid/ready bundle of the polar encoder
// Signals: in_valid/in_ready/info_bits (frame input), out_valid/out_ready/codeword (codeword output).
// Modports: master = traffic source and sink around the encoder, slave = the encoder itself.
interface polar_encoder_if
   import polar_encoder_pkg::*;
#(
   parameter int N = BIT_N,
   parameter int K = BIT_K
);

   logic         in_valid;
   logic         in_ready;
   logic [K-1:0] info_bits;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] codeword;

   modport master (
      output in_valid, info_bits, out_ready,
      input  in_ready, out_valid, codeword
   );

   modport slave (
      input  in_valid, info_bits, out_ready,
      output in_ready, out_valid, codeword
   );

endinterface

// File: rtl/polar_enc_stage.sv
// polar_enc_stage: one combinational butterfly layer of the polar transform u * F^(xLOG2N)
// Ports: i_u (current vector), i_stage (layer index s), o_u_next (vector after layer s).
// Layer s: for every j with bit s clear, u[j] ^= u[j + 2^s]; the partner bit passes through.
module polar_enc_stage #(
   parameter int N = 16,
   parameter int LOG2N = 4
) (
   input  logic [N-1:0]     i_u,
   input  logic [LOG2N-1:0] i_stage,
   output logic [N-1:0]     o_u_next
);

   // every possible layer is built in parallel and the active one is selected;
   // indices s >= LOG2N only exist so the select covers the whole i_stage range
   logic [N-1:0] w_layer [2**LOG2N];

   for (genvar s = 0; s < 2**LOG2N; s++) begin : g_layer
      for (genvar j = 0; j < N; j++) begin : g_bit
         if (s < LOG2N && ((j >> s) & 1) == 0) begin : g_xor
            assign w_layer[s][j] = i_u[j] ^ i_u[j + 2**s];
         end else begin : g_pass
            assign w_layer[s][j] = i_u[j];
         end
      end
   end

   assign o_u_next = w_layer[i_stage];

endmodule

// File: rtl/polar_encoder.sv
// polar_encoder: non-systematic polar encoder, x = u * F^(xLOG2N), F = [1 0; 1 1], natural order
// Ports: clk (rising edge), rst (async, active high),
//        bus (slave): in_valid/in_ready/info_bits accept a K-bit frame,
//                     out_valid/out_ready/codeword deliver the N-bit codeword.
// Info bits are placed on the set bits of FROZEN_MASK (others 0), then LOG2N butterfly
// layers run one per clock before the codeword is presented.
module polar_encoder
   import polar_encoder_pkg::*;
#(
   parameter int N = BIT_N,
   parameter int K = BIT_K,
   parameter int LOG2N = BIT_LOG2N,
   parameter logic [N-1:0] FROZEN_MASK = N'(BIT_FROZEN_MASK)
) (
   input logic           clk,
   input logic           rst,
   polar_encoder_if.slave bus
);

   localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
   localparam logic [MAX_N-1:0] MASK_EXT = MAX_N'(FROZEN_MASK);

   enc_state_t       r_state;
   enc_state_t       w_state_nxt;
   logic [N-1:0]     r_u;
   logic [N-1:0]     w_map;
   logic [N-1:0]     w_u_next;
   logic [LOG2N-1:0] r_cnt;
   logic             w_load;
   logic             w_step;
   logic             w_in_ready;

   if (mask_popcount(MASK_EXT) != K) begin : g_mask_chk
      $error("polar_encoder: FROZEN_MASK popcount %0d differs from K %0d",
             mask_popcount(MASK_EXT), K);
   end

   if (N != 2**LOG2N) begin : g_len_chk
      $error("polar_encoder: N %0d is not 2**LOG2N", N);
   end

   // constant wiring: info bit R lands on the R-th set bit of the mask
   for (genvar i = 0; i < N; i++) begin : g_map
      localparam int R = mask_rank(MASK_EXT, i);
      if (FROZEN_MASK[i] && R < K) begin : g_info
         assign w_map[i] = bus.info_bits[R];
      end else begin : g_frozen
         assign w_map[i] = 1'b0;
      end
   end

   polar_enc_stage #(
      .N(N),
      .LOG2N(LOG2N)
   ) u_stage (
      .i_u     (r_u),
      .i_stage (r_cnt),
      .o_u_next(w_u_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_in_ready  = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ENC;
            end
         end
         ENC: begin
            w_step      = 1'b1;
            w_state_nxt = (r_cnt == LAST_STAGE) ? DONE : ENC;
         end
         DONE: begin
            // ready passes through so a new frame can load on the edge the codeword leaves
            w_in_ready = bus.out_ready;
            if (bus.out_ready) begin
               w_load      = bus.in_valid;
               w_state_nxt = bus.in_valid ? ENC : IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_u   <= '0;
         r_cnt <= '0;
      end else if (w_load) begin
         r_u   <= w_map;
         r_cnt <= '0;
      end else if (w_step) begin
         r_u   <= w_u_next;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.in_ready  = w_in_ready & ~rst;
   assign bus.out_valid = (r_state == DONE);
   assign bus.codeword  = r_u;

endmodule

// File: tb/tb_polar_encoder.sv
// tb_polar_encoder: directed and randomized checks of polar_encoder against a generator-matrix model
module tb_polar_encoder;

   localparam int N = 16;
   localparam int K = 8;
   localparam logic [N-1:0] MASK = 16'hFE80;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   polar_encoder_if #(.N(N), .K(K)) bus ();

   polar_encoder #(
      .N(N),
      .K(K),
      .LOG2N(4),
      .FROZEN_MASK(MASK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // x_j = XOR of u_i over every i whose bit set contains j (row i of F^(x4))
   function automatic logic [N-1:0] ref_encode(input logic [K-1:0] info);
      logic [N-1:0] u;
      logic [N-1:0] x;
      int k;
      u = '0;
      x = '0;
      k = 0;
      for (int i = 0; i < N; i++) begin
         if (MASK[i]) begin
            u[i] = info[k];
            k++;
         end
      end
      for (int j = 0; j < N; j++)
         for (int i = 0; i < N; i++)
            if ((i & j) == j) x[j] = x[j] ^ u[i];
      return x;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic encode(input logic [K-1:0] info, output logic [N-1:0] cw, output int lat);
      int w;
      w = 0;
      bus.info_bits = info;
      bus.in_valid  = 1'b1;
      while (!bus.in_ready && w < 20) begin
         tick();
         w++;
      end
      check("accept_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      cw = bus.codeword;
   endtask

   logic [K-1:0] t_info [4] = '{8'h01, 8'h80, 8'h02, 8'h03};
   logic [N-1:0] t_cw   [4] = '{16'h00FF, 16'hFFFF, 16'h0303, 16'h03FC};

   initial begin
      logic [N-1:0] cw;
      logic [N-1:0] hold_cw;
      logic [N-1:0] exp_q [$];
      int lat;
      int sent;
      int got;
      int cyc;
      bit in_fire;
      bit out_fire;
      bit hold;

      bus.in_valid  = 1'b0;
      bus.info_bits = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_codeword", 32'(bus.codeword), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      tick();

      // zero frame, latency and single-cycle valid
      bus.out_ready = 1'b1;
      encode(8'h00, cw, lat);
      check("zero_cw", 32'(cw), 32'h0000);
      check("latency", 32'(lat), 32'd4);
      tick();
      check("valid_one_cycle", 32'(bus.out_valid), 32'd0);

      // unit vectors and linearity
      for (int t = 0; t < 4; t++) begin
         encode(t_info[t], cw, lat);
         check($sformatf("vec_%0h", t_info[t]), 32'(cw), 32'(t_cw[t]));
         tick();
      end

      // back-pressure in DONE then simultaneous handshake on both ports
      bus.out_ready = 1'b0;
      encode(8'hA5, cw, lat);
      check("stall_cw", 32'(cw), 32'(ref_encode(8'hA5)));
      hold_cw = cw;
      for (int t = 0; t < 10; t++) begin
         tick();
         check("stall_valid", 32'(bus.out_valid), 32'd1);
         check("stall_hold", 32'(bus.codeword), 32'(hold_cw));
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.info_bits = 8'h80;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check("pass_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("b2b_valid_drop", 32'(bus.out_valid), 32'd0);
      check("b2b_enc_not_ready", 32'(bus.in_ready), 32'd0);
      tick();
      tick();
      tick();
      check("b2b_early", 32'(bus.out_valid), 32'd0);
      tick();
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_cw", 32'(bus.codeword), 32'hFFFF);
      tick();

      // reset during stage 2 of ENC
      bus.info_bits = 8'h01;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rst_enc_valid", 32'(bus.out_valid), 32'd0);
      check("rst_enc_cw", 32'(bus.codeword), 32'd0);
      check("rst_enc_ready", 32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      encode(8'h02, cw, lat);
      check("post_rst_cw", 32'(cw), 32'h0303);
      check("post_rst_lat", 32'(lat), 32'd4);
      tick();

      // reset while a codeword waits in DONE
      bus.out_ready = 1'b0;
      encode(8'h80, cw, lat);
      check("done_cw", 32'(cw), 32'hFFFF);
      rst = 1'b1;
      #1;
      check("rst_done_valid", 32'(bus.out_valid), 32'd0);
      check("rst_done_cw", 32'(bus.codeword), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_done_idle", 32'(bus.in_ready), 32'd1);

      // random traffic with stalls on both sides
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 1000 && cyc < 40000) begin
         if (!bus.in_valid && sent < 1000 && $urandom_range(3) != 0) begin
            bus.in_valid  = 1'b1;
            bus.info_bits = K'($urandom);
         end
         bus.out_ready = ($urandom_range(3) != 0);
         #1;
         in_fire  = bus.in_valid && bus.in_ready;
         out_fire = bus.out_valid && bus.out_ready;
         hold     = bus.out_valid && !bus.out_ready;
         hold_cw  = bus.codeword;
         if (out_fire) begin
            check("rnd_expected_frame", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rnd_cw", 32'(bus.codeword), 32'(exp_q.pop_front()));
            got++;
         end
         if (in_fire) begin
            exp_q.push_back(ref_encode(bus.info_bits));
            sent++;
         end
         tick();
         if (in_fire) bus.in_valid = 1'b0;
         if (hold) begin
            check("rnd_hold_valid", 32'(bus.out_valid), 32'd1);
            check("rnd_hold_cw", 32'(bus.codeword), 32'(hold_cw));
         end
         cyc++;
      end
      check("rnd_frames_out", 32'(got), 32'd1000);
      check("rnd_frames_in", 32'(sent), 32'd1000);
      check("rnd_leftover", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
